itcm_port_arb: RTL and testbench

Arbiter and sequencer for the single-ported 64-bit ITCM SRAM macro, which is shared between instruction fetch (IF) and the load/store unit (LS). Each cycle it grants the SRAM to one requester and drives the two 32-bit half-bank chip selects, byte enables and write data. It tracks which requester owns the read in flight and returns read data one cycle later with a valid strobe. LS has priority, bounded by a starvation counter so fetch always makes progress.

---
 rtl/itcm_port_arb.sv | 134 +++++++++++++
 tb/tb_itcm_port_arb.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/itcm_port_arb.sv
`default_nettype none
// ============================================================================
//  Module      : itcm_port_arb
//  Description : Arbiter and sequencer for the single-ported 64-bit ITCM
//                SRAM shared by instruction fetch (IF) and load/store (LS).
//                LS has priority, bounded by a starvation counter so that a
//                waiting fetch is granted after at most STARVE_MAX LS grants.
//                Read data returns one cycle after the grant with a valid
//                strobe routed to the owner of the access.
//  Ports       : clk, cpurst_n          - clock, async active-low reset
//                if_req/if_adr          - fetch request, 64-bit word address
//                if_gnt/if_rvalid/if_rdata  - fetch grant and read response
//                ls_req/ls_adr/ls_we/ls_ben/ls_wdata - LS request
//                ls_gnt/ls_rvalid/ls_rdata  - LS grant and read response
//                sram_*                 - SRAM macro control, address, data
//  Revision    : 1.0 - initial release
// ============================================================================
module itcm_port_arb #(
    parameter int AW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          cpurst_n,
    input  logic          if_req,
    input  logic [28:0]   if_adr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [63:0]   if_rdata,
    input  logic          ls_req,
    input  logic [31:0]   ls_adr,
    input  logic          ls_we,
    input  logic [3:0]    ls_ben,
    input  logic [31:0]   ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [31:0]   ls_rdata,
    output logic          sram_csn0,
    output logic          sram_csn1,
    output logic          sram_wen,
    output logic [AW-1:0] sram_addr,
    output logic [7:0]    sram_ben,
    output logic [63:0]   sram_din,
    input  logic [63:0]   sram_dout
);

    localparam logic [3:0] c_starve_max = STARVE_MAX[3:0];

    logic       r_en;
    logic [3:0] r_starve_cnt;
    logic       r_rsp_if;
    logic       r_rsp_ls;
    logic       r_rsp_hi;

    logic       w_ls_win;
    logic       w_if_win;
    logic       w_unused;

    // LS wins unless IF is waiting and LS has already used its quota.
    assign w_ls_win = r_en && ls_req && (!if_req || (r_starve_cnt < c_starve_max));
    assign w_if_win = r_en && if_req && !w_ls_win;

    assign if_gnt = w_if_win;
    assign ls_gnt = w_ls_win;

    // Byte-offset bits and address bits above the macro are not used.
    assign w_unused = &{1'b0, ls_adr[1:0], ls_adr[31:AW+3], if_adr[28:AW]};

    // SRAM drive. if_adr is already a 64-bit word address (byte bits [31:3]).
    always_comb begin
        sram_csn0 = 1'b1;
        sram_csn1 = 1'b1;
        sram_wen  = 1'b1;
        sram_addr = '0;
        sram_ben  = 8'h00;
        sram_din  = 64'h0;
        if (w_if_win) begin
            sram_csn0 = 1'b0;
            sram_csn1 = 1'b0;
            sram_ben  = 8'hFF;
            sram_addr = if_adr[AW-1:0];
        end else if (w_ls_win) begin
            // Only the 32-bit half addressed by ls_adr[2] is selected.
            sram_addr = ls_adr[AW+2:3];
            sram_csn0 = ls_adr[2];
            sram_csn1 = !ls_adr[2];
            sram_wen  = !ls_we;
            sram_ben  = ls_adr[2] ? {ls_ben, 4'b0000} : {4'b0000, ls_ben};
            sram_din  = {ls_wdata, ls_wdata};
        end
    end

    // Enable flop delays grants by one cycle after reset release.
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            r_en <= 1'b0;
        end else begin
            r_en <= 1'b1;
        end
    end

    // Counts consecutive LS grants taken while IF is waiting.
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            r_starve_cnt <= 4'd0;
        end else if (!if_req || w_if_win) begin
            r_starve_cnt <= 4'd0;
        end else if (w_ls_win && (r_starve_cnt < c_starve_max)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Response ownership for the single access in flight. Writes never
    // produce a response.
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            r_rsp_if <= 1'b0;
            r_rsp_ls <= 1'b0;
            r_rsp_hi <= 1'b0;
        end else begin
            r_rsp_if <= w_if_win;
            r_rsp_ls <= w_ls_win && !ls_we;
            if (w_ls_win) begin
                r_rsp_hi <= ls_adr[2];
            end
        end
    end

    assign if_rvalid = r_rsp_if;
    assign ls_rvalid = r_rsp_ls;
    assign if_rdata  = sram_dout;
    assign ls_rdata  = r_rsp_hi ? sram_dout[63:32] : sram_dout[31:0];

endmodule
`default_nettype wire

// File: tb/tb_itcm_port_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_itcm_port_arb
//  Description : Directed self-checking testbench for itcm_port_arb.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_itcm_port_arb;

    localparam int AW         = 16;
    localparam int STARVE_MAX = 4;

    logic          clk;
    logic          cpurst_n;
    logic          if_req;
    logic [28:0]   if_adr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [63:0]   if_rdata;
    logic          ls_req;
    logic [31:0]   ls_adr;
    logic          ls_we;
    logic [3:0]    ls_ben;
    logic [31:0]   ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [31:0]   ls_rdata;
    logic          sram_csn0;
    logic          sram_csn1;
    logic          sram_wen;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_ben;
    logic [63:0]   sram_din;
    logic [63:0]   sram_dout;

    int checks;
    int failures;

    itcm_port_arb #(
        .AW         (AW),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .cpurst_n  (cpurst_n),
        .if_req    (if_req),
        .if_adr    (if_adr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_adr    (ls_adr),
        .ls_we     (ls_we),
        .ls_ben    (ls_ben),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .sram_csn0 (sram_csn0),
        .sram_csn1 (sram_csn1),
        .sram_wen  (sram_wen),
        .sram_addr (sram_addr),
        .sram_ben  (sram_ben),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 2 time units after the next rising edge; inputs are driven
    // there and outputs are sampled 2 units later, well away from the edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        cpurst_n  = 1'b0;
        if_req    = 1'b0;
        if_adr    = 29'h0;
        ls_req    = 1'b0;
        ls_adr    = 32'h0;
        ls_we     = 1'b0;
        ls_ben    = 4'h0;
        ls_wdata  = 32'h0;
        sram_dout = 64'h0;
        repeat (2) cyc();
        #2;
        checks++;
        if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_handshake: got %b expected 0000",
                     {if_gnt, ls_gnt, if_rvalid, ls_rvalid});
        end
        checks++;
        if ({sram_csn0, sram_csn1, sram_wen, sram_ben, sram_addr, sram_din} !==
            {1'b1, 1'b1, 1'b1, 8'h00, 16'h0000, 64'h0}) begin
            failures++;
            $display("FAIL reset_sram: got csn=%b%b wen=%b ben=%h addr=%h din=%h expected 1 1 1 00 0000 0",
                     sram_csn0, sram_csn1, sram_wen, sram_ben, sram_addr, sram_din);
        end
        // Release mid-cycle with a fetch already pending: en is still 0.
        cyc();
        cpurst_n = 1'b1;
        if_req   = 1'b1;
        if_adr   = 29'h0000_0010;
        #2;
        checks++;
        if ({if_gnt, sram_csn0, sram_csn1} !== 3'b011) begin
            failures++;
            $display("FAIL first_cycle_no_grant: got gnt=%b csn=%b%b expected gnt=0 csn=11",
                     if_gnt, sram_csn0, sram_csn1);
        end
        if_req = 1'b0;
    endtask

    task automatic test_single_fetch();
        cyc();
        if_req = 1'b1;
        if_adr = 29'h0000_0010;
        #2;
        checks++;
        if ({if_gnt, ls_gnt} !== 2'b10) begin
            failures++;
            $display("FAIL fetch_gnt: got if_gnt=%b ls_gnt=%b expected 1 0", if_gnt, ls_gnt);
        end
        checks++;
        if ({sram_addr, sram_csn0, sram_csn1, sram_wen, sram_ben} !==
            {16'h0010, 1'b0, 1'b0, 1'b1, 8'hFF}) begin
            failures++;
            $display("FAIL fetch_sram: got addr=%h csn=%b%b wen=%b ben=%h expected 0010 00 1 ff",
                     sram_addr, sram_csn0, sram_csn1, sram_wen, sram_ben);
        end
        cyc();
        if_req    = 1'b0;
        sram_dout = 64'h1122_3344_5566_7788;
        #2;
        checks++;
        if ({if_rvalid, ls_rvalid, if_rdata} !== {1'b1, 1'b0, 64'h1122_3344_5566_7788}) begin
            failures++;
            $display("FAIL fetch_rsp: got if_rvalid=%b ls_rvalid=%b rdata=%h expected 1 0 1122334455667788",
                     if_rvalid, ls_rvalid, if_rdata);
        end
    endtask

    task automatic test_ls_read_hi();
        cyc();
        ls_req = 1'b1;
        ls_adr = 32'h0000_0084;
        ls_ben = 4'hF;
        ls_we  = 1'b0;
        #2;
        checks++;
        if ({ls_gnt, if_gnt, sram_addr, sram_csn0, sram_csn1, sram_wen, sram_ben} !==
            {1'b1, 1'b0, 16'h0010, 1'b1, 1'b0, 1'b1, 8'hF0}) begin
            failures++;
            $display("FAIL ls_read_hi_req: got gnt=%b addr=%h csn=%b%b wen=%b ben=%h expected 1 0010 10 1 f0",
                     ls_gnt, sram_addr, sram_csn0, sram_csn1, sram_wen, sram_ben);
        end
        cyc();
        ls_req    = 1'b0;
        sram_dout = 64'hDEAD_BEEF_0123_4567;
        #2;
        checks++;
        if ({ls_rvalid, if_rvalid, ls_rdata} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL ls_read_hi_rsp: got rvalid=%b if_rvalid=%b rdata=%h expected 1 0 deadbeef",
                     ls_rvalid, if_rvalid, ls_rdata);
        end
    endtask

    task automatic test_ls_write_lo();
        cyc();
        ls_req   = 1'b1;
        ls_adr   = 32'h0000_0081;
        ls_ben   = 4'h2;
        ls_we    = 1'b1;
        ls_wdata = 32'hAABB_CCDD;
        #2;
        checks++;
        if ({ls_gnt, sram_addr, sram_csn0, sram_csn1, sram_wen, sram_ben} !==
            {1'b1, 16'h0010, 1'b0, 1'b1, 1'b0, 8'h02}) begin
            failures++;
            $display("FAIL ls_write_lo_ctrl: got gnt=%b addr=%h csn=%b%b wen=%b ben=%h expected 1 0010 01 0 02",
                     ls_gnt, sram_addr, sram_csn0, sram_csn1, sram_wen, sram_ben);
        end
        checks++;
        if (sram_din !== 64'hAABB_CCDD_AABB_CCDD) begin
            failures++;
            $display("FAIL ls_write_lo_din: got %h expected aabbccddaabbccdd", sram_din);
        end
        cyc();
        ls_req = 1'b0;
        ls_we  = 1'b0;
        #2;
        checks++;
        if ({ls_rvalid, if_rvalid} !== 2'b00) begin
            failures++;
            $display("FAIL ls_write_no_rsp: got ls_rvalid=%b if_rvalid=%b expected 0 0",
                     ls_rvalid, if_rvalid);
        end
    endtask

    task automatic test_back_to_back();
        // Fetch, then low-lane LS read, then idle: each response lands on
        // the correct owner one cycle after its grant.
        cyc();
        if_req = 1'b1;
        if_adr = 29'h0000_0020;
        #2;
        checks++;
        if ({if_gnt, sram_addr} !== {1'b1, 16'h0020}) begin
            failures++;
            $display("FAIL b2b_fetch: got gnt=%b addr=%h expected 1 0020", if_gnt, sram_addr);
        end
        cyc();
        if_req    = 1'b0;
        ls_req    = 1'b1;
        ls_adr    = 32'h0000_0100;
        ls_ben    = 4'hF;
        ls_we     = 1'b0;
        sram_dout = 64'hCAFE_F00D_8765_4321;
        #2;
        checks++;
        if ({ls_gnt, if_rvalid, if_rdata, sram_addr, sram_csn0, sram_csn1, sram_ben} !==
            {1'b1, 1'b1, 64'hCAFE_F00D_8765_4321, 16'h0020, 1'b0, 1'b1, 8'h0F}) begin
            failures++;
            $display("FAIL b2b_ls_lo: got gnt=%b if_rvalid=%b if_rdata=%h addr=%h csn=%b%b ben=%h",
                     ls_gnt, if_rvalid, if_rdata, sram_addr, sram_csn0, sram_csn1, sram_ben);
        end
        cyc();
        ls_req    = 1'b0;
        sram_dout = 64'h0BAD_0BAD_5A5A_A5A5;
        #2;
        checks++;
        if ({ls_rvalid, if_rvalid, ls_rdata} !== {1'b1, 1'b0, 32'h5A5A_A5A5}) begin
            failures++;
            $display("FAIL b2b_ls_rsp: got rvalid=%b if_rvalid=%b rdata=%h expected 1 0 5a5aa5a5",
                     ls_rvalid, if_rvalid, ls_rdata);
        end
    endtask

    task automatic test_starvation();
        logic exp_if;
        logic prev_if;
        cyc();
        if_req = 1'b0;
        ls_req = 1'b0;
        #2;
        prev_if = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if_req = 1'b1;
            if_adr = 29'h0000_0040;
            ls_req = 1'b1;
            ls_adr = 32'h0000_0200;
            ls_we  = 1'b0;
            #2;
            exp_if = (i == 4) || (i == 9);
            checks++;
            if ({if_gnt, ls_gnt} !== {exp_if, !exp_if}) begin
                failures++;
                $display("FAIL starve_grant[%0d]: got if_gnt=%b ls_gnt=%b expected %b %b",
                         i, if_gnt, ls_gnt, exp_if, !exp_if);
            end
            if (i > 0) begin
                checks++;
                if ({if_rvalid, ls_rvalid} !== {prev_if, !prev_if}) begin
                    failures++;
                    $display("FAIL starve_rsp[%0d]: got if_rvalid=%b ls_rvalid=%b expected %b %b",
                             i, if_rvalid, ls_rvalid, prev_if, !prev_if);
                end
            end
            prev_if = exp_if;
        end
        cyc();
        if_req = 1'b0;
        ls_req = 1'b0;
        #2;
    endtask

    task automatic test_counter_clear();
        logic exp_if;
        cyc();
        #2;
        for (int i = 0; i < 9; i++) begin
            cyc();
            ls_req = 1'b1;
            ls_adr = 32'h0000_0084;
            ls_we  = 1'b0;
            if_req = (i != 3);
            if_adr = 29'h0000_0050;
            #2;
            exp_if = (i == 8);
            checks++;
            if ({if_gnt, ls_gnt} !== {exp_if, !exp_if}) begin
                failures++;
                $display("FAIL cnt_clear_grant[%0d]: got if_gnt=%b ls_gnt=%b expected %b %b",
                         i, if_gnt, ls_gnt, exp_if, !exp_if);
            end
        end
        cyc();
        if_req = 1'b0;
        ls_req = 1'b0;
        #2;
    endtask

    task automatic test_async_reset();
        // Read in flight when reset asserts.
        cyc();
        ls_req = 1'b1;
        ls_adr = 32'h0000_0084;
        ls_we  = 1'b0;
        #2;
        checks++;
        if (ls_gnt !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre_gnt: got %b expected 1", ls_gnt);
        end
        cyc();
        ls_req = 1'b0;
        #1;
        checks++;
        if (ls_rvalid !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre_rvalid: got %b expected 1", ls_rvalid);
        end
        cpurst_n = 1'b0;
        #1;
        checks++;
        if ({ls_rvalid, if_rvalid} !== 2'b00) begin
            failures++;
            $display("FAIL areset_rvalid_drop: got ls=%b if=%b expected 0 0", ls_rvalid, if_rvalid);
        end
        cyc();
        cpurst_n = 1'b1;
        // Grant cycle interrupted by reset: grant and selects drop at once.
        cyc();
        cyc();
        ls_req = 1'b1;
        #1;
        checks++;
        if (ls_gnt !== 1'b1) begin
            failures++;
            $display("FAIL areset_grant2: got %b expected 1", ls_gnt);
        end
        cpurst_n = 1'b0;
        #1;
        checks++;
        if ({ls_gnt, if_gnt, sram_csn0, sram_csn1, sram_wen, sram_ben} !==
            {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00}) begin
            failures++;
            $display("FAIL areset_selects: got gnt=%b%b csn=%b%b wen=%b ben=%h expected 00 11 1 00",
                     ls_gnt, if_gnt, sram_csn0, sram_csn1, sram_wen, sram_ben);
        end
        ls_req = 1'b0;
        cyc();
        cpurst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            #2;
            checks++;
            if ({ls_rvalid, if_rvalid} !== 2'b00) begin
                failures++;
                $display("FAIL areset_no_stale[%0d]: got ls=%b if=%b expected 0 0",
                         i, ls_rvalid, if_rvalid);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_fetch();
        test_ls_read_hi();
        test_ls_write_lo();
        test_back_to_back();
        test_starvation();
        test_counter_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
